alu_multicycle: RTL

Parametrised, registered ALU for the single-cycle MIPS datapath's multi-cycle successor. Keeps the existing 5-bit opcode map but adds a start/busy/done handshake. Most operations complete in one clock; multiply and divide are iterative, one result bit per clock. Results, zero and overflow flags are registered and held until the next completion. The block sits between the register-file read ports and the writeback mux, and stalls the pipeline control while `busy` is high.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_muldiv.sv | 72 +++++++
 rtl/alu_multicycle.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state type for the multi-cycle ALU slice.
// Imported by the ALU top, its iterative datapath and the decode/writeback logic.
package alu_pkg;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_MUL = 5'b00010;
   localparam logic [4:0] ALU_DIV = 5'b00011;
   localparam logic [4:0] ALU_NOT = 5'b00100;
   localparam logic [4:0] ALU_AND = 5'b00101;
   localparam logic [4:0] ALU_OR  = 5'b00110;
   localparam logic [4:0] ALU_XOR = 5'b00111;
   localparam logic [4:0] ALU_SLL = 5'b01000;
   localparam logic [4:0] ALU_SRL = 5'b01001;
   localparam logic [4:0] ALU_LT  = 5'b01010;
   localparam logic [4:0] ALU_GT  = 5'b01011;
   localparam logic [4:0] ALU_EQ  = 5'b01100;
   localparam logic [4:0] ALU_LE  = 5'b01101;
   localparam logic [4:0] ALU_GE  = 5'b01110;
   localparam logic [4:0] ALU_NE  = 5'b01111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one result bit per clock.
// lo/hi present the accumulator after the current step; fin marks the final step.
module alu_iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             fin,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CNT_W = $clog2(WIDTH);

   logic             run;
   logic             div_mode;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_rem;
   logic             div_borrow_unused;
   logic             div_fits;

   assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_fits  = (div_shift >= {1'b0, opnd});
   assign {div_borrow_unused, div_rem} = div_shift - {1'b0, opnd};

   always_comb begin
      if (div_mode) begin
         hi = div_fits ? div_rem : div_shift[WIDTH-1:0];
         lo = {acc_lo[WIDTH-2:0], div_fits};
      end else begin
         hi = mul_sum[WIDTH:1];
         lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   assign fin = run && (cnt == '0);

   // A zero divisor is replaced by 1 so the quotient falls out as op1 with remainder 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         run      <= 1'b0;
         div_mode <= 1'b0;
         cnt      <= '0;
         opnd     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
      end else if (go) begin
         run      <= 1'b1;
         div_mode <= is_div;
         cnt      <= CNT_W'(WIDTH - 1);
         opnd     <= (is_div && (op2 == '0)) ? {{(WIDTH-1){1'b0}}, 1'b1} : op2;
         acc_hi   <= '0;
         acc_lo   <= op1;
      end else if (run) begin
         acc_hi <= hi;
         acc_lo <= lo;
         cnt    <= cnt - CNT_W'(1);
         if (cnt == '0) run <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with start/busy/done handshake; mul/div run through alu_iter_muldiv.
// Define ALU_MULTICYCLE_HI_EN to add result_hi (mul upper half, div remainder).
//
// state   | meaning
// ST_IDLE | waiting for start; single-cycle ops complete here
// ST_MUL  | shift-add multiply in progress, busy=1
// ST_DIV  | restoring divide in progress, busy=1
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [4:0]         OPcode,
   input  logic [WIDTH-1:0]   op1,
   input  logic [WIDTH-1:0]   op2,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               overflow_add,
   output logic               overflow_sub,
   output logic               div_zero
`ifdef ALU_MULTICYCLE_HI_EN
   ,
   output logic [WIDTH-1:0]   result_hi
`endif
);

   alu_state_t       state;
   logic             accept;
   logic             is_div_op;
   logic             is_iter;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] sc_result;
   logic             ovf_add_c;
   logic             ovf_sub_c;
   logic             pend_add;
   logic             pend_sub;
   logic             pend_dz;
   logic             iter_fin;
   logic [WIDTH-1:0] iter_lo;
`ifdef ALU_MULTICYCLE_HI_EN
   logic [WIDTH-1:0] iter_hi;
`else
   logic [WIDTH-1:0] iter_hi_unused;
`endif

   assign busy      = (state != ST_IDLE);
   assign accept    = start && (state == ST_IDLE);
   assign is_div_op = (OPcode == ALU_DIV);
   assign is_iter   = (OPcode == ALU_MUL) || is_div_op;
   assign sum       = op1 + op2;
   assign diff      = op1 - op2;
   assign ovf_add_c = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1]  != op1[WIDTH-1]);
   assign ovf_sub_c = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);

   always_comb begin
      sc_result = '0;
      case (OPcode)
         ALU_ADD: sc_result = sum;
         ALU_SUB: sc_result = diff;
         ALU_NOT: sc_result = ~op1;
         ALU_AND: sc_result = op1 & op2;
         ALU_OR:  sc_result = op1 | op2;
         ALU_XOR: sc_result = op1 ^ op2;
         ALU_SLL: sc_result = op1 << shamt;
         ALU_SRL: sc_result = op1 >> shamt;
         ALU_LT:  sc_result = {{(WIDTH-1){1'b0}}, (op1 <  op2)};
         ALU_GT:  sc_result = {{(WIDTH-1){1'b0}}, (op1 >  op2)};
         ALU_EQ:  sc_result = {{(WIDTH-1){1'b0}}, (op1 == op2)};
         ALU_LE:  sc_result = {{(WIDTH-1){1'b0}}, (op1 <= op2)};
         ALU_GE:  sc_result = {{(WIDTH-1){1'b0}}, (op1 >= op2)};
         ALU_NE:  sc_result = {{(WIDTH-1){1'b0}}, (op1 != op2)};
         default: sc_result = '0;
      endcase
   end

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
      .clock  (clock),
      .reset  (reset),
      .go     (accept && is_iter),
      .is_div (is_div_op),
      .op1    (op1),
      .op2    (op2),
      .fin    (iter_fin),
      .lo     (iter_lo),
`ifdef ALU_MULTICYCLE_HI_EN
      .hi     (iter_hi)
`else
      .hi     (iter_hi_unused)
`endif
   );

   // Flags for mul/div are taken from the operands at acceptance and published at completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         done         <= 1'b0;
         result       <= '0;
         zero         <= 1'b1;
         overflow_add <= 1'b0;
         overflow_sub <= 1'b0;
         div_zero     <= 1'b0;
         pend_add     <= 1'b0;
         pend_sub     <= 1'b0;
         pend_dz      <= 1'b0;
`ifdef ALU_MULTICYCLE_HI_EN
         result_hi    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (is_iter) begin
                     state    <= is_div_op ? ST_DIV : ST_MUL;
                     pend_add <= ovf_add_c;
                     pend_sub <= ovf_sub_c;
                     pend_dz  <= (op2 == '0);
                  end else begin
                     done         <= 1'b1;
                     result       <= sc_result;
                     zero         <= (sc_result == '0);
                     overflow_add <= ovf_add_c;
                     overflow_sub <= ovf_sub_c;
                     div_zero     <= 1'b0;
`ifdef ALU_MULTICYCLE_HI_EN
                     result_hi    <= '0;
`endif
                  end
               end
            end
            default: begin
               if (iter_fin) begin
                  state        <= ST_IDLE;
                  done         <= 1'b1;
                  result       <= iter_lo;
                  zero         <= (iter_lo == '0);
                  overflow_add <= pend_add;
                  overflow_sub <= pend_sub;
                  div_zero     <= (state == ST_DIV) && pend_dz;
`ifdef ALU_MULTICYCLE_HI_EN
                  result_hi    <= iter_hi;
`endif
               end
            end
         endcase
      end
   end

endmodule
